// File: rtl/cmd_pkg.sv
// Shared opcodes, header field layout and sequencer states for the command fetch path.
package cmd_pkg;

  localparam logic [7:0] OP_VERTEX = 8'h03;
  localparam logic [7:0] OP_COLOR  = 8'h04;
  localparam logic [7:0] OP_FLUSH  = 8'h05;
  localparam logic [7:0] OP_JUMP   = 8'h06;
  localparam logic [7:0] OP_MATRIX = 8'h16;

  localparam int unsigned HDR_FLAG_BIT = 31;
  localparam int unsigned HDR_LEN_MSB  = 15;
  localparam int unsigned HDR_LEN_LSB  = 8;
  localparam int unsigned HDR_OP_MSB   = 7;
  localparam int unsigned HDR_OP_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_PAYLOAD,
    ST_FLUSH_WAIT,
    ST_FAULT
  } cmd_state_t;

endpackage

// File: rtl/cmd_decode.sv
// Combinational header classifier: splits a header word into opcode/length
// and flags exactly one of payload, flush, jump, no-op or bad.
module cmd_decode
  import cmd_pkg::*;
(
  input  logic [31:0] header,
  output logic [7:0]  opcode,
  output logic [7:0]  len,
  output logic        is_payload,
  output logic        is_flush,
  output logic        is_jump,
  output logic        is_nop,
  output logic        is_bad
);

  logic flag;
  logic known_payload;

  always_comb begin
    opcode        = header[HDR_OP_MSB:HDR_OP_LSB];
    len           = header[HDR_LEN_MSB:HDR_LEN_LSB];
    flag          = header[HDR_FLAG_BIT];
    known_payload = (opcode == OP_MATRIX) || (opcode == OP_COLOR) || (opcode == OP_VERTEX);
    is_nop        = (header == '0);
    is_payload    = flag && known_payload && (len != '0);
    is_flush      = !flag && (opcode == OP_FLUSH);
    is_jump       = !flag && (opcode == OP_JUMP);
    is_bad        = !(is_nop || is_payload || is_flush || is_jump);
  end

endmodule

// File: rtl/cmd_fetch_ctrl.sv
// Command-stream sequencer: decodes headers from the BRAM and streams payload beats.
// Optional CMD_FETCH_PERF_EN adds saturating perf_cmds / perf_stall counters.
module cmd_fetch_ctrl
  import cmd_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] START_PC  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         halt,
  output logic [31:0]  addr1,
  output logic [31:0]  addr2,
  input  logic [31:0]  read0,
  input  logic [31:0]  read1,
  input  logic [31:0]  read2,
  input  logic [31:0]  read3,
  input  logic [31:0]  read4,
  output logic         beat_valid,
  input  logic         beat_ready,
  output logic [7:0]   beat_opcode,
  output logic [127:0] beat_data,
  output logic [2:0]   beat_words,
  output logic         beat_first,
  output logic         beat_last,
  output logic         flush_req,
  input  logic         flush_done,
  output logic         busy,
  output logic         fault,
  output logic [31:0]  fault_pc
`ifdef CMD_FETCH_PERF_EN
  ,
  output logic [31:0]  perf_cmds,
  output logic [31:0]  perf_stall
`endif
);

  localparam logic [32:0] DEPTH = 33'(MEM_DEPTH);

  cmd_state_t  state, state_n;
  logic [31:0] pc, pc_n, ptr, ptr_n, fault_pc_q, fault_pc_n;
  logic [7:0]  rem, rem_n, op_q, op_n;
  logic        first_q, first_n, flush_arm, flush_arm_n, fault_q, fault_n;
  logic        retire, go_fault;
  logic [2:0]  words;
  logic [7:0]  dec_op, dec_len;
  logic        dec_payload, dec_flush, dec_jump, dec_nop, dec_bad;

  cmd_decode u_decode (
    .header     (read0),
    .opcode     (dec_op),
    .len        (dec_len),
    .is_payload (dec_payload),
    .is_flush   (dec_flush),
    .is_jump    (dec_jump),
    .is_nop     (dec_nop),
    .is_bad     (dec_bad)
  );

  assign words = (rem >= 8'd4) ? 3'd4 : rem[2:0];

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ptr_n       = ptr;
    rem_n       = rem;
    op_n        = op_q;
    first_n     = first_q;
    flush_arm_n = flush_arm;
    fault_n     = fault_q;
    fault_pc_n  = fault_pc_q;
    retire      = 1'b0;
    go_fault    = 1'b0;
    unique case (state)
      ST_DECODE: begin
        if (!halt) begin
          // Whole payload span is bounds-checked here so no beat is ever emitted for a bad command.
          if ({1'b0, pc} >= DEPTH) begin
            go_fault = 1'b1;
          end else if (dec_payload) begin
            if ({1'b0, pc} + {25'b0, dec_len} >= DEPTH) begin
              go_fault = 1'b1;
            end else begin
              op_n    = dec_op;
              rem_n   = dec_len;
              ptr_n   = pc + 32'd1;
              first_n = 1'b1;
              state_n = ST_PAYLOAD;
            end
          end else if (dec_flush) begin
            flush_arm_n = 1'b0;
            state_n     = ST_FLUSH_WAIT;
          end else if (dec_jump) begin
            if (({1'b0, pc} + 33'd1 >= DEPTH) || ({1'b0, read1} >= DEPTH)) begin
              go_fault = 1'b1;
            end else begin
              pc_n   = read1;
              retire = 1'b1;
            end
          end else if (dec_nop) begin
            pc_n   = pc + 32'd1;
            retire = 1'b1;
          end else if (dec_bad) begin
            go_fault = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (beat_ready) begin
          ptr_n   = ptr + {29'b0, words};
          rem_n   = rem - {5'b0, words};
          first_n = 1'b0;
          if (rem == {5'b0, words}) begin
            pc_n    = ptr_n;
            state_n = ST_DECODE;
            retire  = 1'b1;
          end
        end
      end
      ST_FLUSH_WAIT: begin
        flush_arm_n = 1'b1;
        if (flush_done && flush_arm) begin
          pc_n    = pc + 32'd1;
          state_n = ST_DECODE;
          retire  = 1'b1;
        end
      end
      default: ;
    endcase
    if (go_fault) begin
      state_n    = ST_FAULT;
      fault_n    = 1'b1;
      fault_pc_n = pc;
    end
    if (start) begin
      state_n     = ST_DECODE;
      pc_n        = START_PC;
      fault_n     = 1'b0;
      first_n     = 1'b0;
      flush_arm_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= START_PC;
      ptr        <= '0;
      rem        <= '0;
      op_q       <= '0;
      first_q    <= 1'b0;
      flush_arm  <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ptr        <= ptr_n;
      rem        <= rem_n;
      op_q       <= op_n;
      first_q    <= first_n;
      flush_arm  <= flush_arm_n;
      fault_q    <= fault_n;
      fault_pc_q <= fault_pc_n;
    end
  end

  assign addr1       = pc;
  assign addr2       = (state == ST_PAYLOAD) ? ptr : pc + 32'd1;
  assign beat_valid  = (state == ST_PAYLOAD);
  assign beat_opcode = op_q;
  assign beat_words  = beat_valid ? words : '0;
  assign beat_first  = beat_valid && first_q;
  assign beat_last   = beat_valid && (rem <= 8'd4);
  assign beat_data   = {read1, read2, read3, read4};
  assign flush_req   = (state == ST_FLUSH_WAIT);
  assign busy        = (state != ST_IDLE) && (state != ST_FAULT);
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;

`ifdef CMD_FETCH_PERF_EN
  logic [31:0] cmds_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmds_q  <= '0;
      stall_q <= '0;
    end else if (start) begin
      cmds_q  <= '0;
      stall_q <= '0;
    end else begin
      if (retire && (cmds_q != '1))
        cmds_q <= cmds_q + 32'd1;
      if (beat_valid && !beat_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cmds  = cmds_q;
  assign perf_stall = stall_q;
`else
  logic perf_unused;
  assign perf_unused = retire;
`endif

endmodule

// File: tb/tb_cmd_fetch_ctrl.sv
// Self-checking bench for cmd_fetch_ctrl: directed vectors, corner sequences and
// randomized programs compared against a command-level reference model.
module tb_cmd_fetch_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BAD   = 32'h8000_0099;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, halt = 1'b0, beat_ready = 1'b0, flush_done = 1'b0;
  logic [31:0]  addr1, addr2, read0, read1, read2, read3, read4, fault_pc;
  logic         beat_valid, beat_first, beat_last, flush_req, busy, fault;
  logic [7:0]   beat_opcode;
  logic [127:0] beat_data;
  logic [2:0]   beat_words;
`ifdef CMD_FETCH_PERF_EN
  logic [31:0]  perf_cmds, perf_stall;
`endif

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] a2p1, a2p2, a2p3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign a2p1  = addr2 + 32'd1;
  assign a2p2  = addr2 + 32'd2;
  assign a2p3  = addr2 + 32'd3;
  assign read0 = (addr1 < DEPTH) ? mem[addr1[9:0]] : '0;
  assign read1 = (addr2 < DEPTH) ? mem[addr2[9:0]] : '0;
  assign read2 = (a2p1 < DEPTH) ? mem[a2p1[9:0]] : '0;
  assign read3 = (a2p2 < DEPTH) ? mem[a2p2[9:0]] : '0;
  assign read4 = (a2p3 < DEPTH) ? mem[a2p3[9:0]] : '0;

  cmd_fetch_ctrl #(.MEM_DEPTH(1024), .START_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .addr1(addr1), .addr2(addr2),
    .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_opcode(beat_opcode),
    .beat_data(beat_data), .beat_words(beat_words), .beat_first(beat_first),
    .beat_last(beat_last), .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy), .fault(fault), .fault_pc(fault_pc)
`ifdef CMD_FETCH_PERF_EN
    , .perf_cmds(perf_cmds), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = BAD;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; beat_ready = 1'b0; flush_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return (a < DEPTH) ? mem[a[9:0]] : '0;
  endfunction

  function automatic logic [127:0] mat_beat(input int b);
    logic [31:0] base;
    base = 32'hA000_0000 + 32'(1 + 4 * b);
    return {base, base + 32'd1, base + 32'd2, base + 32'd3};
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [31:0] hdr;
    logic [31:0] op1;
    logic [31:0] at;
    logic        valid;
    logic [2:0]  words;
    logic        first;
    logic        last;
    logic        flush;
    logic        flt;
    logic [31:0] fpc;
    logic        bsy;
    logic [31:0] a1;
    logic [31:0] a2;
  } vec_t;

  vec_t vecs [12];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]   op;
    logic [2:0]   words;
    logic         first;
    logic         last;
    logic [127:0] data;
  } beat_t;

  beat_t       exp_q [$];
  int unsigned exp_flush, exp_retired;
  logic [31:0] exp_fpc;

  task automatic gen_prog();
    int unsigned p, L, gap;
    logic [7:0] op;
    fill_mem();
    p = 0;
    while (p < 780) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          case ($urandom_range(0, 2))
            0: op = 8'h03;
            1: op = 8'h04;
            default: op = 8'h16;
          endcase
          L = $urandom_range(1, 20);
          mem[p] = {1'b1, 15'b0, L[7:0], op};
          for (int unsigned k = 1; k <= L; k++) mem[p + k] = $urandom;
          p += L + 1;
        end
        2: begin mem[p] = 32'h0; p += 1; end
        3: begin mem[p] = 32'h5; p += 1; end
        default: begin
          gap = $urandom_range(0, 3);
          mem[p]     = 32'h6;
          mem[p + 1] = p + 2 + gap;
          for (int unsigned k = 0; k < gap; k++) mem[p + 2 + k] = $urandom;
          p += 2 + gap;
        end
      endcase
    end
    case ($urandom_range(0, 2))
      0: mem[p] = BAD;
      1: begin mem[p] = 32'h6; mem[p + 1] = 32'd2000; end
      default: mem[p] = 32'h8000_FF03;
    endcase
  endtask

  task automatic model_run();
    logic [31:0] p, h;
    int unsigned L, w;
    logic [7:0] op;
    bit done;
    beat_t b;
    exp_q.delete();
    exp_flush = 0; exp_retired = 0; exp_fpc = '0;
    p = 0; done = 0;
    for (int g = 0; g < 4096 && !done; g++) begin
      h = rdm(p); op = h[7:0]; L = int'(h[15:8]);
      if (p >= DEPTH) begin
        exp_fpc = p; done = 1;
      end else if (h == 32'h0) begin
        p += 1; exp_retired++;
      end else if (h[31] && L != 0 && (op == 8'h03 || op == 8'h04 || op == 8'h16)) begin
        if (p + L >= DEPTH) begin
          exp_fpc = p; done = 1;
        end else begin
          for (int unsigned off = 0; off < L; off += 4) begin
            w = (L - off > 4) ? 4 : L - off;
            b.op = op; b.words = 3'(w); b.first = (off == 0); b.last = (off + w == L);
            b.data = {rdm(p + 1 + off), rdm(p + 2 + off), rdm(p + 3 + off), rdm(p + 4 + off)};
            exp_q.push_back(b);
          end
          p += L + 1; exp_retired++;
        end
      end else if (!h[31] && op == 8'h05) begin
        exp_flush++; p += 1; exp_retired++;
      end else if (!h[31] && op == 8'h06) begin
        if (p + 1 >= DEPTH || rdm(p + 1) >= DEPTH) begin
          exp_fpc = p; done = 1;
        end else begin
          p = rdm(p + 1); exp_retired++;
        end
      end else begin
        exp_fpc = p; done = 1;
      end
    end
  endtask

  task automatic run_random();
    int unsigned cyc, flushes, stalls;
    logic prev_fr;
    beat_t e;
    gen_prog();
    model_run();
    do_reset();
    pulse_start();
    cyc = 0; flushes = 0; stalls = 0; prev_fr = 1'b0;
    while (!fault && cyc < 8000) begin
      if (flush_req && !prev_fr) flushes++;
      prev_fr    = flush_req;
      flush_done = ($urandom_range(0, 2) == 0);
      beat_ready = ($urandom_range(0, 3) != 0);
      if (beat_valid) begin
        if (!beat_ready) stalls++;
        else if (exp_q.size() == 0) chk("rnd_extra_beat", beat_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_beat", {beat_opcode, beat_words, beat_first, beat_last, beat_data}, e);
        end
      end
      step();
      cyc++;
    end
    beat_ready = 1'b0; flush_done = 1'b0;
    chk("rnd_reached_fault", fault, 1'b1);
    chk("rnd_beats_left", exp_q.size(), 0);
    chk("rnd_flush_count", flushes, exp_flush);
    chk("rnd_fault_pc", fault_pc, exp_fpc);
`ifdef CMD_FETCH_PERF_EN
    chk("rnd_perf_stall", perf_stall, stalls);
    chk("rnd_perf_cmds", perf_cmds, exp_retired);
`endif
  endtask

  initial begin
    vecs[0]  = '{32'h8000_0304, 32'h3F80_0000, 32'd17,   1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,    1'b1, 32'd17,   32'd18};
    vecs[1]  = '{32'h8000_1016, 32'h1111_1111, 32'd2,    1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,    1'b1, 32'd2,    32'd3};
    vecs[2]  = '{32'h8000_0303, 32'h2222_2222, 32'd100,  1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,    1'b1, 32'd100,  32'd101};
    vecs[3]  = '{32'h8000_0099, 32'h0,         32'd5,    1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5,    1'b0, 32'd5,    32'd6};
    vecs[4]  = '{32'h8000_0004, 32'h0,         32'd7,    1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7,    1'b0, 32'd7,    32'd8};
    vecs[5]  = '{32'h0000_0005, 32'h0,         32'd41,   1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,    1'b1, 32'd41,   32'd42};
    vecs[6]  = '{32'h0000_0006, 32'd300,       32'd42,   1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    1'b1, 32'd300,  32'd301};
    vecs[7]  = '{32'h0000_0006, 32'd1024,      32'd10,   1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd10,   1'b0, 32'd10,   32'd11};
    vecs[8]  = '{32'h0000_0000, 32'h0,         32'd50,   1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    1'b1, 32'd51,   32'd52};
    vecs[9]  = '{32'h8000_0404, 32'h3333_3333, 32'd1020, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1020, 1'b0, 32'd1020, 32'd1021};
    vecs[10] = '{32'h8000_0404, 32'h4444_4444, 32'd1019, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,    1'b1, 32'd1019, 32'd1020};
    vecs[11] = '{32'h8000_0116, 32'h5555_5555, 32'd1022, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,    1'b1, 32'd1022, 32'd1023};

    fill_mem();
    do_reset();
    chk("rst_addr1", addr1, 32'd0);
    chk("rst_addr2", addr2, 32'd1);
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_flush_req", flush_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_pc", fault_pc, 32'd0);

    // Each vector: jump from 0 to the header's address, then look one cycle after its decode.
    for (int i = 0; i < 12; i++) begin
      fill_mem();
      mem[0] = 32'h6;
      mem[1] = vecs[i].at;
      mem[vecs[i].at[9:0]] = vecs[i].hdr;
      if (vecs[i].at + 1 < DEPTH) mem[vecs[i].at[9:0] + 10'd1] = vecs[i].op1;
      do_reset();
      pulse_start();
      step(); step();
      chk($sformatf("vec%0d", i),
          {beat_valid, beat_words, beat_first, beat_last, flush_req, fault, fault_pc, busy, addr1, addr2},
          {vecs[i].valid, vecs[i].words, vecs[i].first, vecs[i].last, vecs[i].flush, vecs[i].flt,
           vecs[i].fpc, vecs[i].bsy, vecs[i].a1, vecs[i].a2});
      if (vecs[i].valid) chk($sformatf("vec%0d_word0", i), beat_data[127:96], vecs[i].op1);
    end

    // Matrix at 0, colour at 17, bad header at 21.
    fill_mem();
    mem[0] = 32'h8000_1016;
    for (int i = 1; i <= 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[17] = 32'h8000_0304; mem[18] = 32'h3F80_0000; mem[19] = 32'h0; mem[20] = 32'h0;
    do_reset();
    beat_ready = 1'b1;
    pulse_start();
    chk("a_dec_busy", busy, 1'b1);
    chk("a_dec_valid", beat_valid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk($sformatf("a_beat%0d", b), {beat_valid, beat_opcode, beat_words, beat_first, beat_last, beat_data},
          {1'b1, 8'h16, 3'd4, b == 0, b == 3, mat_beat(b)});
    end
    step();
    chk("a_pc17", {beat_valid, addr1}, {1'b0, 32'd17});
    step();
    chk("a_colour", {beat_valid, beat_opcode, beat_words, beat_first, beat_last, beat_data[127:96]},
        {1'b1, 8'h04, 3'd3, 1'b1, 1'b1, 32'h3F80_0000});
    step();
    chk("a_pc21", {beat_valid, addr1}, {1'b0, 32'd21});
    step();
    chk("a_fault", {fault, fault_pc, busy, beat_valid}, {1'b1, 32'd21, 1'b0, 1'b0});
    pulse_start();
    chk("a_restart", {fault, addr1, busy}, {1'b0, 32'd0, 1'b1});

    // Backpressure on beat 2 for three cycles.
    step();
    step();
    beat_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("b_hold%0d", k), {beat_valid, beat_words, beat_first, beat_data},
          {1'b1, 3'd4, 1'b0, mat_beat(1)});
    end
    beat_ready = 1'b1;
    step();
    chk("b_beat3", {beat_valid, beat_last, beat_data}, {1'b1, 1'b0, mat_beat(2)});
    step();
    chk("b_beat4", {beat_valid, beat_last, beat_data}, {1'b1, 1'b1, mat_beat(3)});
    step();
    chk("b_pc17", addr1, 32'd17);
`ifdef CMD_FETCH_PERF_EN
    chk("b_perf_stall", perf_stall, 32'd3);
    chk("b_perf_cmds", perf_cmds, 32'd1);
`endif

    // Asynchronous reset while the colour beat is pending.
    beat_ready = 1'b0;
    step();
    chk("d_pre_valid", beat_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("d_rst_strobes", {beat_valid, beat_first, beat_last, flush_req, busy, fault}, 6'b0);
    chk("d_rst_regs", {addr1, addr2, fault_pc}, {32'd0, 32'd1, 32'd0});
    step();
    rst_n = 1'b1;
    step();

    // Flush at 41 with an early (ignored) done pulse, then jump at 42 to 0.
    fill_mem();
    mem[0] = 32'h6; mem[1] = 32'd41; mem[41] = 32'h5; mem[42] = 32'h6; mem[43] = 32'd0;
    do_reset();
    pulse_start();
    step();
    chk("c_at41", addr1, 32'd41);
    step();
    chk("c_fr1", flush_req, 1'b1);
    flush_done = 1'b1;
    step();
    flush_done = 1'b0;
    chk("c_fr2_first_done_ignored", flush_req, 1'b1);
    step();
    chk("c_fr3", flush_req, 1'b1);
    step();
    chk("c_fr4", flush_req, 1'b1);
    flush_done = 1'b1;
    step();
    flush_done = 1'b0;
    chk("c_after_flush", {flush_req, addr1}, {1'b0, 32'd42});
    step();
    chk("c_jump", addr1, 32'd0);

    // Start aborts a payload; halt blocks decode but not a running payload.
    fill_mem();
    mem[0] = 32'h8000_1016;
    for (int i = 1; i <= 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    do_reset();
    pulse_start();
    step();
    chk("e_beat1", beat_valid, 1'b1);
    pulse_start();
    chk("e_abort", {beat_valid, beat_first, addr1, busy}, {1'b0, 1'b0, 32'd0, 1'b1});
    halt = 1'b1;
    step();
    chk("e_halt1", {beat_valid, addr1, busy}, {1'b0, 32'd0, 1'b1});
    step();
    chk("e_halt2", {beat_valid, addr1}, {1'b0, 32'd0});
    halt = 1'b0;
    step();
    chk("e_resume", {beat_valid, beat_first, beat_data}, {1'b1, 1'b1, mat_beat(0)});
    halt = 1'b1;
    beat_ready = 1'b1;
    step();
    chk("e_halt_payload", {beat_valid, beat_first, beat_data}, {1'b1, 1'b0, mat_beat(1)});
    step(); step(); step();
    step();
    chk("e_halt_decode", {beat_valid, addr1, busy}, {1'b0, 32'd17, 1'b1});
    halt = 1'b0;
    beat_ready = 1'b0;

    for (int r = 0; r < 3; r++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
